force_release_sched: RTL
========================

# force_release_sched

Arbitrates force/release requests from several requesters onto a shared 8-lane override array, such as an array of interface signals. Each requester can force a lane to a value or release it, with an optional hold time that ends in an automatic release. Each output lane drives either its normal source or its forced value. The block sits between test-control agents and the lane datapath, and keeps the force and release ordering deterministic for emulation.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LANES, 8, number of override lanes
- TMR_W, 8, hold-timer width; a duration of 0 means the force is held indefinitely

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; when low, no request is accepted and timers freeze
- rel_all  input  1  single-cycle pulse that releases every lane
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept, one-hot or zero
- req_op  input  NREQ  per-requester operation: 1 = force, 0 = release
- req_lane  input  NREQ*3  per-requester lane index, packed with requester r at [3r+2:3r]
- req_val  input  NREQ  per-requester force value
- req_dur  input  NREQ*TMR_W  per-requester hold duration, packed
- i_a  input  LANES  normal lane sources
- o_a  output  LANES  lane outputs
- forced  output  LANES  per-lane force-active flags
- busy  output  1  high while any lane is forced

## Operation
- Per-lane state: frc (1 bit), fval (1 bit), tmr (TMR_W bits), all registered.
- o_a[i] = frc[i] ? fval[i] : i_a[i]. This is combinational, so i_a reaches o_a with zero latency when the lane is not forced.
- forced = frc. busy = |frc.

Arbitration:
- A round-robin arbiter picks among the asserted req_valid bits. Search starts at ptr, ptr resets to 0, and after each grant ptr becomes (granted index + 1) mod NREQ.
- req_ready[g] is asserted combinationally in the same cycle for the winner g, only when en=1 and rel_all=0.
- A handshake is valid & ready. At most one handshake occurs per cycle.
- A requester holds valid and its fields stable until ready. A requester that drops valid without ready has its request discarded; the block keeps no side state for it.

Effects of an accepted request, applied at the next edge:
- Force to lane L: frc[L]=1, fval[L]=val, tmr[L]=dur. This overwrites any existing force and timer on L.
- Release to lane L: frc[L]=0, tmr[L]=0. Releasing a lane that is not forced is a legal no-op and is still acknowledged.
- A lane index of LANES or above is acknowledged and ignored.

Timers:
- Each cycle with en=1, every lane with frc=1 and tmr>1 decrements.
- A lane with frc=1 and tmr==1 auto-releases: frc=0, tmr=0.
- A lane with tmr==0 holds its force indefinitely.

Precedence, highest first:
- rel_all clears all frc and tmr. No request is accepted in that cycle.
- An accepted request on lane L overrides that cycle's timer action on L. A force on an expiring lane re-forces it; a release gives the same result as expiry.
- Timer actions.

## Timing
- Request-to-effect latency: handshake in cycle n; frc, fval and o_a update after the edge ending cycle n.
- Force with duration D≥1 accepted in cycle n: o_a shows fval for exactly D cycles (n+1 .. n+D) while en stays 1. The lane reverts to i_a from cycle n+D+1.
- When en is held low the timers pause, so the lane stays forced for D cycles of en=1 rather than D clock cycles.
- Throughput: one request per cycle. With NREQ requesters all continuously valid, each requester is granted once every NREQ cycles.
- Reset, asynchronous at any point including mid-hold: frc=0, fval=0, tmr=0, ptr=0. Outputs during reset: o_a=i_a, forced=0, busy=0, req_ready=0.
- Deassertion of reset must be synchronised to clk outside this block.
- rel_all is sampled synchronously; an asserted rel_all causes no acceptance in that cycle.

## Structure
- Package force_sched_pkg:
  - typedef fr_op_e with FR_RELEASE=0 and FR_FORCE=1
  - LANE_IDX_W=3
  - a function for the round-robin next-pointer calculation
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; outputs the one-hot grant and the grant index.
- The top level holds the request decode, the lane state array, the timer logic and the output mux.

## Test plan
- Basic force and release:
  - req0 force lane 3, val=1, dur=0, with i_a=0x00 → o_a=0x08 from the next cycle, forced=0x08, busy=1.
  - req0 then releases lane 3 → o_a=0x00 one cycle after the handshake, busy=0.
- Timed release: force lane 5, val=0, dur=4, with i_a=0xFF → o_a=0xDF for exactly 4 cycles, then 0xFF.
  - Repeat with en low for 3 cycles mid-hold → the force lasts 7 cycles.
- Round-robin: all 4 requesters continuously valid, each forcing a distinct lane → grant order 0,1,2,3,0 with exactly one req_ready per cycle.
- Simultaneous events:
  - A force lands on lane 2 in the cycle its tmr==1 → lane 2 stays forced with the new val and timer.
  - rel_all together with a valid request → all lanes released, req_ready=0, the request is accepted the following cycle.
- Reset mid-hold: assert rst_n low during a dur=10 force → o_a follows i_a immediately, forced=0.
  - After release from reset, ptr=0, so requester 0 wins first when all requesters are valid.
- Edge inputs:
  - Release of an unforced lane → acknowledged, no change.
  - Force to lane index 7 with LANES=8 → lane 7 is forced.

Source files
------------

// File: rtl/force_sched_pkg.sv
// force_sched_pkg: shared types, widths and the round-robin pointer helper.
package force_sched_pkg;

    typedef enum logic {
        FR_RELEASE = 1'b0,
        FR_FORCE   = 1'b1
    } fr_op_e;

    localparam int LANE_IDX_W = 3;

    // The search for the next grant starts one past the last winner, wrapping at n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/force_release_sched_rr_arbiter.sv
// rr_arbiter: picks one asserted request, searching upward from ptr with wrap.
//   req : request vector
//   ptr : index where the search starts
//   gnt : one-hot grant, zero when no request is asserted
//   idx : index of the granted request, zero when none
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/force_release_sched.sv
// force_release_sched: arbitrates force/release requests onto an override lane array.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable; gates acceptance and timer countdown
//   rel_all    : releases every lane, blocks acceptance that cycle
//   req_*      : per-requester valid/op/lane/value/duration, ready is one-hot or zero
//   i_a, o_a   : normal lane sources and overridden lane outputs
//   forced     : per-lane force-active flags; busy = any lane forced
module force_release_sched
    import force_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LANES = 8,
    parameter int TMR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       rel_all,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_op,
    input  logic [NREQ*LANE_IDX_W-1:0] req_lane,
    input  logic [NREQ-1:0]            req_val,
    input  logic [NREQ*TMR_W-1:0]      req_dur,
    input  logic [LANES-1:0]           i_a,
    output logic [LANES-1:0]           o_a,
    output logic [LANES-1:0]           forced,
    output logic                       busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]                 ptr;
    logic [PW-1:0]                 gidx;
    logic [NREQ-1:0]               gnt;
    logic                          hs;
    logic [LANE_IDX_W-1:0]         sel_lane;
    fr_op_e                        sel_op;
    logic                          sel_val;
    logic [TMR_W-1:0]              sel_dur;
    logic [LANES-1:0]              frc;
    logic [LANES-1:0]              fval;
    logic [LANES-1:0][TMR_W-1:0]   tmr;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gidx)
    );

    // rst_n gates ready so nothing is acknowledged while reset is held.
    assign req_ready = (rst_n && en && !rel_all) ? gnt : '0;
    assign hs        = |req_ready;

    assign sel_lane = req_lane[int'(gidx)*LANE_IDX_W +: LANE_IDX_W];
    assign sel_op   = fr_op_e'(req_op[gidx]);
    assign sel_val  = req_val[gidx];
    assign sel_dur  = req_dur[int'(gidx)*TMR_W +: TMR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (hs) ptr <= PW'(rr_next(int'(gidx), NREQ));
    end

    // Per lane: rel_all beats an accepted request, which beats the timer.
    // Lane indices outside the array match no lane and so are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frc  <= '0;
            fval <= '0;
            tmr  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (rel_all) begin
                    frc[i] <= 1'b0;
                    tmr[i] <= '0;
                end else if (hs && int'(sel_lane) == i) begin
                    frc[i] <= (sel_op == FR_FORCE);
                    tmr[i] <= (sel_op == FR_FORCE) ? sel_dur : '0;
                    if (sel_op == FR_FORCE) fval[i] <= sel_val;
                end else if (en && frc[i] && tmr[i] == TMR_W'(1)) begin
                    frc[i] <= 1'b0;
                    tmr[i] <= '0;
                end else if (en && frc[i] && tmr[i] > TMR_W'(1)) begin
                    tmr[i] <= tmr[i] - TMR_W'(1);
                end
            end
        end
    end

    assign o_a    = (frc & fval) | (~frc & i_a);
    assign forced = frc;
    assign busy   = |frc;

endmodule
